// File: rtl/pe_credit_endpoint.sv
// rtl/pe_credit_endpoint.sv - mesh PE endpoint: credit-gated injection FIFO, ejection FIFO with credit return
module pe_credit_endpoint #(
  parameter int FLIT_W    = 20,
  parameter int CREDITS   = 4,
  parameter int INJ_DEPTH = 8,
  parameter int EJ_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [FLIT_W-1:0]            inj_data,
  input  logic                         inj_valid,
  output logic                         inj_ready,
  output logic [FLIT_W-1:0]            dataout,
  output logic                         out_valid,
  input  logic                         ci,
  input  logic [FLIT_W-1:0]            datain,
  input  logic                         in_valid,
  output logic                         co,
  output logic [FLIT_W-1:0]            ej_data,
  output logic                         ej_valid,
  input  logic                         ej_ready,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                         err_ovf
);

  localparam int CW  = $clog2(CREDITS+1);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int IOW = $clog2(INJ_DEPTH+1);
  localparam int EAW = $clog2(EJ_DEPTH);
  localparam int EOW = $clog2(EJ_DEPTH+1);
  localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);
  localparam logic [IOW-1:0] INJ_FULL = IOW'(INJ_DEPTH);
  localparam logic [EOW-1:0] EJ_FULL  = EOW'(EJ_DEPTH);

  logic [FLIT_W-1:0] inj_mem [INJ_DEPTH];
  logic [FLIT_W-1:0] ej_mem  [EJ_DEPTH];

  logic [IAW-1:0]    inj_wptr_q, inj_wptr_d, inj_rptr_q, inj_rptr_d;
  logic [IOW-1:0]    inj_cnt_q, inj_cnt_d;
  logic [EAW-1:0]    ej_wptr_q, ej_wptr_d, ej_rptr_q, ej_rptr_d;
  logic [EOW-1:0]    ej_cnt_q, ej_cnt_d;
  logic [FLIT_W-1:0] dataout_q, dataout_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              co_q, co_d;
  logic              err_q, err_d;

  logic inj_push, send, ej_push, ej_pop, ej_drop, cred_ovf;

  always_comb begin
    inj_push = inj_valid && (inj_cnt_q != INJ_FULL);
    send     = (inj_cnt_q != '0) && (credit_q != '0);

    inj_wptr_d  = inj_wptr_q + IAW'(inj_push);
    inj_rptr_d  = inj_rptr_q + IAW'(send);
    inj_cnt_d   = inj_cnt_q + IOW'(inj_push) - IOW'(send);
    dataout_d   = send ? inj_mem[inj_rptr_q] : dataout_q;
    out_valid_d = send;

    // A returned credit with nothing outstanding saturates and flags the router's mistake.
    credit_d = credit_q;
    cred_ovf = 1'b0;
    if (send && !ci) begin
      credit_d = credit_q - CW'(1);
    end else if (!send && ci) begin
      if (credit_q == CRED_MAX) cred_ovf = 1'b1;
      else                      credit_d = credit_q + CW'(1);
    end

    ej_pop  = (ej_cnt_q != '0) && ej_ready;
    ej_push = in_valid && ((ej_cnt_q != EJ_FULL) || ej_pop);
    ej_drop = in_valid && !ej_push;

    ej_wptr_d = ej_wptr_q + EAW'(ej_push);
    ej_rptr_d = ej_rptr_q + EAW'(ej_pop);
    ej_cnt_d  = ej_cnt_q + EOW'(ej_push) - EOW'(ej_pop);
    co_d      = ej_pop;
    err_d     = err_q || ej_drop || cred_ovf;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      inj_wptr_q  <= '0;
      inj_rptr_q  <= '0;
      inj_cnt_q   <= '0;
      ej_wptr_q   <= '0;
      ej_rptr_q   <= '0;
      ej_cnt_q    <= '0;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
      credit_q    <= CRED_MAX;
      co_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      inj_wptr_q  <= inj_wptr_d;
      inj_rptr_q  <= inj_rptr_d;
      inj_cnt_q   <= inj_cnt_d;
      ej_wptr_q   <= ej_wptr_d;
      ej_rptr_q   <= ej_rptr_d;
      ej_cnt_q    <= ej_cnt_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
      credit_q    <= credit_d;
      co_q        <= co_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST && inj_push) inj_mem[inj_wptr_q] <= inj_data;
    if (!RST && ej_push)  ej_mem[ej_wptr_q]   <= datain;
  end

  assign inj_ready  = (inj_cnt_q != INJ_FULL);
  assign dataout    = dataout_q;
  assign out_valid  = out_valid_q;
  assign co         = co_q;
  assign ej_data    = ej_mem[ej_rptr_q];
  assign ej_valid   = (ej_cnt_q != '0);
  assign credit_cnt = credit_q;
  assign err_ovf    = err_q;

endmodule

// File: tb/tb_pe_credit_endpoint.sv
// tb/tb_pe_credit_endpoint.sv - directed self-checking bench for pe_credit_endpoint
module tb_pe_credit_endpoint;

  logic        clk = 1'b0;
  logic        RST;
  logic [19:0] inj_data;
  logic        inj_valid;
  logic        inj_ready;
  logic [19:0] dataout;
  logic        out_valid;
  logic        ci;
  logic [19:0] datain;
  logic        in_valid;
  logic        co;
  logic [19:0] ej_data;
  logic        ej_valid;
  logic        ej_ready;
  logic [2:0]  credit_cnt;
  logic        err_ovf;

  int tests  = 0;
  int failed = 0;

  pe_credit_endpoint #(.FLIT_W(20), .CREDITS(4), .INJ_DEPTH(8), .EJ_DEPTH(4)) dut (
    .clk(clk), .RST(RST),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .dataout(dataout), .out_valid(out_valid), .ci(ci),
    .datain(datain), .in_valid(in_valid), .co(co),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .credit_cnt(credit_cnt), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; inj_valid = 1'b0; ci = 1'b0; in_valid = 1'b0; ej_ready = 1'b0;
    inj_data = '0; datain = '0;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    int sent;
    // 1: reset state, then three back-to-back flits
    do_reset();
    chk("rst_credit", 32'(credit_cnt), 32'd4);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dataout", 32'(dataout), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_err", 32'(err_ovf), 32'd0);
    chk("rst_inj_ready", 32'(inj_ready), 32'd1);
    chk("rst_ej_valid", 32'(ej_valid), 32'd0);

    inj_valid = 1'b1; inj_data = 20'h00001; tick();
    chk("t1_lat_ov", 32'(out_valid), 32'd0);
    inj_data = 20'h00002; tick();
    chk("t1_f1_ov", 32'(out_valid), 32'd1);
    chk("t1_f1_data", 32'(dataout), 32'h1);
    chk("t1_f1_cred", 32'(credit_cnt), 32'd3);
    inj_data = 20'h00003; tick();
    chk("t1_f2_ov", 32'(out_valid), 32'd1);
    chk("t1_f2_data", 32'(dataout), 32'h2);
    chk("t1_f2_cred", 32'(credit_cnt), 32'd2);
    inj_valid = 1'b0; tick();
    chk("t1_f3_ov", 32'(out_valid), 32'd1);
    chk("t1_f3_data", 32'(dataout), 32'h3);
    chk("t1_f3_cred", 32'(credit_cnt), 32'd1);
    tick();
    chk("t1_idle_ov", 32'(out_valid), 32'd0);
    chk("t1_idle_data", 32'(dataout), 32'h3);

    // 2: six flits, only four credits
    do_reset();
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      inj_valid = (i < 6);
      inj_data  = 20'(32'h10 + i);
      tick();
      if (out_valid) begin
        chk("t2_order", 32'(dataout), 32'h10 + 32'(sent));
        sent++;
      end
    end
    inj_valid = 1'b0;
    chk("t2_sent", 32'(sent), 32'd4);
    chk("t2_cred0", 32'(credit_cnt), 32'd0);
    chk("t2_ov_low", 32'(out_valid), 32'd0);
    ci = 1'b1; tick(); ci = 1'b0;
    chk("t2_ci_ov", 32'(out_valid), 32'd0);
    tick();
    chk("t2_f5_ov", 32'(out_valid), 32'd1);
    chk("t2_f5_data", 32'(dataout), 32'h14);
    chk("t2_f5_cred", 32'(credit_cnt), 32'd0);

    // 3: send and credit return in the same cycle at credit_cnt=2
    do_reset();
    inj_valid = 1'b1; inj_data = 20'h20; tick();
    inj_data = 20'h21; tick();
    inj_valid = 1'b0; tick();
    chk("t3_cred2", 32'(credit_cnt), 32'd2);
    inj_valid = 1'b1; inj_data = 20'h22; tick();
    inj_valid = 1'b0; ci = 1'b1; tick(); ci = 1'b0;
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_data", 32'(dataout), 32'h22);
    chk("t3_cred", 32'(credit_cnt), 32'd2);
    chk("t3_err", 32'(err_ovf), 32'd0);

    // 5: credit overflow is saturating and sticky
    do_reset();
    ci = 1'b1; tick(); ci = 1'b0;
    chk("t5_cred", 32'(credit_cnt), 32'd4);
    chk("t5_err", 32'(err_ovf), 32'd1);
    tick(); tick();
    chk("t5_sticky", 32'(err_ovf), 32'd1);

    // 4: ejection fill, overflow drop, drain with credit return
    do_reset();
    chk("t4_err_clr", 32'(err_ovf), 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; datain = 20'(32'h30 + i); tick();
      chk("t4_fill_co", 32'(co), 32'd0);
    end
    chk("t4_full_err", 32'(err_ovf), 32'd0);
    chk("t4_full_valid", 32'(ej_valid), 32'd1);
    datain = 20'h34; tick(); in_valid = 1'b0;
    chk("t4_drop_err", 32'(err_ovf), 32'd1);
    chk("t4_drop_head", 32'(ej_data), 32'h30);
    chk("t4_drop_co", 32'(co), 32'd0);
    ej_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain_valid", 32'(ej_valid), 32'd1);
      chk("t4_drain_data", 32'(ej_data), 32'h30 + 32'(i));
      tick();
      chk("t4_drain_co", 32'(co), 32'd1);
    end
    chk("t4_empty", 32'(ej_valid), 32'd0);
    tick();
    chk("t4_co_end", 32'(co), 32'd0);
    ej_ready = 1'b0;

    // 6: reset mid-operation with queued flits
    do_reset();
    in_valid = 1'b1; datain = 20'h55;
    for (int i = 0; i < 8; i++) begin
      inj_valid = 1'b1; inj_data = 20'(32'h40 + i); tick();
      in_valid = 1'b0;
    end
    inj_data = 20'h48; ci = 1'b1; tick();
    inj_valid = 1'b0; ci = 1'b0;
    chk("t6_pre_cred", 32'(credit_cnt), 32'd1);
    chk("t6_pre_ejv", 32'(ej_valid), 32'd1);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("t6_inj_ready", 32'(inj_ready), 32'd1);
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_cred", 32'(credit_cnt), 32'd4);
    chk("t6_ejv", 32'(ej_valid), 32'd0);
    sent = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) sent++;
    end
    chk("t6_no_stale", 32'(sent), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
